// File: rtl/spi_frame_rx_pkg.sv
// Shared frame geometry and receiver state encoding for the SPI work-frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_frame_rx_pkg;

    localparam int SHAPOOL_FRAME_WIDTH = 352;

    localparam int MIDSTATE_MSB = 351;
    localparam int MIDSTATE_LSB = 96;
    localparam int TAIL_MSB     = 95;
    localparam int TAIL_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } rx_state_t;

    function automatic logic [MIDSTATE_MSB-MIDSTATE_LSB:0] frame_midstate(
        input logic [SHAPOOL_FRAME_WIDTH-1:0] frame
    );
        return frame[MIDSTATE_MSB:MIDSTATE_LSB];
    endfunction

    function automatic logic [TAIL_MSB-TAIL_LSB:0] frame_tail(
        input logic [SHAPOOL_FRAME_WIDTH-1:0] frame
    );
        return frame[TAIL_MSB:TAIL_LSB];
    endfunction

endpackage

// File: rtl/spi_frame_rx_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; emits synced level and single-cycle rise/fall.
// Latency: level 2 clk, edges valid combinationally from stage 2 vs history.
// Backpressure: none; free-running.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            hist <= RESET_VAL;
        end else begin
            s1   <= din;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~hist;
    assign fall  = ~s2 & hist;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI mode-0 slave: deserializes one MSB-first frame, strobes it out on cs_n rise.
// Latency: data_valid_out on the 4th clk_in edge after cs_n_in rises at the pin.
// Backpressure: none; consumer samples data_out on the strobe or any time after. Daisy: SHAPOOL_SPI_RX_DAISY_EN.
import spi_frame_rx_pkg::*;

module spi_frame_rx #(
    parameter int DATA_WIDTH  = SHAPOOL_FRAME_WIDTH,
    parameter int COUNT_WIDTH = 9
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_n_in,
    output logic                  sdo_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  busy_out,
    output logic                  error_out
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DATA_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(DATA_WIDTH + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic cs_lvl, cs_rise, cs_fall;

    sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk_in), .rst_n(reset_n_in), .din(sck_in),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk_in), .rst_n(reset_n_in), .din(sdi_in),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk_in), .rst_n(reset_n_in), .din(cs_n_in),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, sck_fall, sdi_rise, sdi_fall, cs_lvl};

    rx_state_t              state;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [COUNT_WIDTH-1:0] count;
    logic                   frame_ok;

`ifdef SHAPOOL_SPI_RX_DAISY_EN
    assign frame_ok = (count >= COUNT_FULL);
`else
    assign frame_ok = (count == COUNT_FULL);
`endif

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= ST_IDLE;
            shreg          <= '0;
            count          <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            busy_out       <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_SHIFT;
                        shreg     <= '0;
                        count     <= '0;
                        error_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Frame end takes priority: a coincident sck edge is dropped.
                    if (cs_rise) begin
                        state    <= ST_DONE;
                        busy_out <= 1'b0;
                    end else if (sck_rise) begin
                        shreg <= {shreg[DATA_WIDTH-2:0], sdi_lvl};
                        if (count != COUNT_MAX) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_ok) begin
                        data_out       <= shreg;
                        data_valid_out <= 1'b1;
                    end else begin
                        error_out <= 1'b1;
                    end
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHAPOOL_SPI_RX_DAISY_EN
    logic sdo_q;

    // Launch on sck fall so the downstream device samples a stable bit on its rise.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sdo_q <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if (sck_fall) begin
                sdo_q <= shreg[DATA_WIDTH-1];
            end
        end else if (state == ST_IDLE) begin
            sdo_q <= 1'b0;
        end
    end

    assign sdo_out = sdo_q;
`else
    assign sdo_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized SPI frame stimulus against a bit-queue reference model; scoreboard checks strobes.
module tb_spi_frame_rx;
    import spi_frame_rx_pkg::*;

    localparam int W = SHAPOOL_FRAME_WIDTH;

    logic         clk_in = 1'b0;
    logic         reset_n_in;
    logic         sck_in;
    logic         sdi_in;
    logic         cs_n_in;
    logic         sdo_out;
    logic [W-1:0] data_out;
    logic         data_valid_out;
    logic         busy_out;
    logic         error_out;

    spi_frame_rx dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .sck_in(sck_in),
        .sdi_in(sdi_in),
        .cs_n_in(cs_n_in),
        .sdo_out(sdo_out),
        .data_out(data_out),
        .data_valid_out(data_valid_out),
        .busy_out(busy_out),
        .error_out(error_out)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    bit           frame_q[$];
    logic [W-1:0] last_data;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (reset_n_in === 1'b1 && data_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                chk("strobe_data", data_out, e.data);
                chk("strobe_latency", W'(cyc - e.cyc), W'(4));
            end
        end
    end

    task automatic fill_random(input int n);
        frame_q.delete();
        repeat (n) frame_q.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic fill_byte(input logic [7:0] b, input int nbytes);
        frame_q.delete();
        repeat (nbytes) begin
            for (int k = 7; k >= 0; k--) frame_q.push_back(b[k]);
        end
    endtask

    // Reference: a frame's kept bits are all sampled bits, minus one that coincides with cs_n rise.
    task automatic run_frame(input int half, input bit collide, input string tag);
        int           n;
        int           kept_n;
        bit           ok;
        logic [W-1:0] d;
        n      = frame_q.size();
        kept_n = (collide && n > 0) ? n - 1 : n;
`ifdef SHAPOOL_SPI_RX_DAISY_EN
        ok = (kept_n >= W);
`else
        ok = (kept_n == W);
`endif
        d = '0;
        if (ok) begin
            for (int i = 0; i < W; i++) d[W-1-i] = frame_q[kept_n - W + i];
        end

        cs_n_in = 1'b0;
        wait_clk(6);
        chk({tag, "_busy_in_frame"}, W'(busy_out), W'(1));
        chk({tag, "_err_cleared"}, W'(error_out), W'(0));

        for (int i = 0; i < n; i++) begin
            sdi_in = frame_q[i];
            wait_clk(half);
            sck_in = 1'b1;
            if (collide && i == n - 1) begin
                if (ok) exp_q.push_back('{d, cyc});
                cs_n_in = 1'b1;
            end
            wait_clk(half);
            sck_in = 1'b0;
        end
        if (!(collide && n > 0)) begin
            wait_clk(5);
            if (ok) exp_q.push_back('{d, cyc});
            cs_n_in = 1'b1;
        end
        if (ok) last_data = d;

        wait_clk(8);
        chk({tag, "_error"}, W'(error_out), W'(!ok));
        chk({tag, "_busy_after"}, W'(busy_out), W'(0));
        chk({tag, "_data_held"}, data_out, last_data);
        chk({tag, "_sdo_idle"}, W'(sdo_out), W'(0));
    endtask

    initial begin
        reset_n_in = 1'b0;
        sck_in     = 1'b0;
        sdi_in     = 1'b0;
        cs_n_in    = 1'b1;
        last_data  = '0;
        wait_clk(3);
        chk("rst_data", data_out, W'(0));
        chk("rst_valid", W'(data_valid_out), W'(0));
        chk("rst_busy", W'(busy_out), W'(0));
        chk("rst_error", W'(error_out), W'(0));
        chk("rst_sdo", W'(sdo_out), W'(0));
        reset_n_in = 1'b1;
        wait_clk(5);

        fill_byte(8'hA5, W / 8);
        run_frame(5, 1'b0, "a5");
        chk("a5_midstate", W'(frame_midstate(data_out)), W'({32{8'hA5}}));
        chk("a5_tail", W'(frame_tail(data_out)), W'({12{8'hA5}}));

        fill_random(W - 1);
        run_frame($urandom_range(4, 6), 1'b0, "short");

        fill_random(W);
        run_frame($urandom_range(4, 6), 1'b0, "good1");

        fill_random(W);
        run_frame($urandom_range(4, 6), 1'b1, "coll_w");

        fill_random(W + 1);
        run_frame($urandom_range(4, 6), 1'b1, "coll_w1");

        // Partial frame killed by reset; cs_n is released while reset is held.
        fill_random(200);
        cs_n_in = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 200; i++) begin
            sdi_in = frame_q[i];
            wait_clk(4);
            sck_in = 1'b1;
            wait_clk(4);
            sck_in = 1'b0;
        end
        reset_n_in = 1'b0;
        #1;
        chk("midrst_data", data_out, W'(0));
        chk("midrst_busy", W'(busy_out), W'(0));
        cs_n_in = 1'b1;
        wait_clk(4);
        reset_n_in = 1'b1;
        last_data  = '0;
        wait_clk(6);
        chk("postrst_busy", W'(busy_out), W'(0));
        chk("postrst_error", W'(error_out), W'(0));
        chk("postrst_data", data_out, W'(0));

        fill_byte(8'h3C, W / 8);
        run_frame(4, 1'b0, "x3c");

        frame_q.delete();
        run_frame(4, 1'b0, "zero");

        fill_random(W + 1);
        run_frame($urandom_range(4, 6), 1'b0, "long");

        fill_random(W);
        run_frame($urandom_range(4, 6), 1'b0, "good2");

        wait_clk(10);
        chk("sb_drain", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
